// File: rtl/alu16_seq_if.sv
// Bundle between alu16_seq, the execute stage (request/response) and the 8-bit ALU.
// The slave modport is the sequencer; the master modport is everything around it.
interface alu16_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_err;
  logic        flag_c;
  logic        flag_z;
  logic        flag_n;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_mode;
  logic        alu_cin;
  logic [7:0]  alu_out;
  logic        alu_cout;
  logic        alu_zout;
  logic        alu_nout;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    input  alu_out, alu_cout, alu_zout, alu_nout,
    output req_ready, rsp_valid, rsp_result, rsp_err,
    output flag_c, flag_z, flag_n,
    output alu_a, alu_b, alu_mode, alu_cin
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    output alu_out, alu_cout, alu_zout, alu_nout,
    input  req_ready, rsp_valid, rsp_result, rsp_err,
    input  flag_c, flag_z, flag_n,
    input  alu_a, alu_b, alu_mode, alu_cin
  );
endinterface

// File: rtl/alu16_seq.sv
// 16-bit operation sequencer over an 8-bit ALU: low byte, then high byte, then respond.
// Define ALU16_SHIFT_EN to enable SRL16/SRA16 (ops 9 and 10); otherwise they are illegal.
module alu16_seq #(
  parameter logic [2:0] RST_FLAGS = 3'b000
) (
  input  logic        clk,
  input  logic        rst,
  alu16_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        r_seed;
  logic [7:0]  r_res_lo;
  logic        r_chain_c;
  logic [15:0] r_rsp_result;
  logic        r_rsp_err;
  logic        r_flag_c;
  logic        r_flag_z;
  logic        r_flag_n;

  logic        w_legal;
  logic        w_arith;
  logic        w_shift;
  logic        w_sra;
  logic [7:0]  w_lo_byte;
  logic [7:0]  w_hi_byte;
  logic [15:0] w_res16;
  logic        w_unused;

  function automatic logic op_is_legal(input logic [3:0] op);
`ifdef ALU16_SHIFT_EN
    return (op <= OP_SRA);
`else
    return (op <= OP_CMP);
`endif
  endfunction

  function automatic logic op_is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) ||
           (op == OP_SBB) || (op == OP_CMP);
  endfunction

  // Subtract-type ops run SUB then SBB so the borrow chains into the high byte.
  function automatic logic [3:0] alu_mode_for(input logic [3:0] op, input logic hi);
    case (op)
      OP_ADD:         return hi ? 4'b0101 : 4'b0100;
      OP_ADC:         return 4'b0101;
      OP_SUB, OP_CMP: return hi ? 4'b1000 : 4'b0111;
      OP_SBB:         return 4'b1000;
      OP_AND:         return 4'b0001;
      OP_OR:          return 4'b0010;
      OP_XOR:         return 4'b0011;
      OP_NOT:         return 4'b1001;
`ifdef ALU16_SHIFT_EN
      OP_SRL:         return 4'b1011;
      OP_SRA:         return 4'b1100;
`endif
      default:        return 4'b0000;
    endcase
  endfunction

  assign w_legal = op_is_legal(r_op);
  assign w_arith = op_is_arith(r_op);
`ifdef ALU16_SHIFT_EN
  assign w_shift = (r_op == OP_SRL) || (r_op == OP_SRA);
  assign w_sra   = (r_op == OP_SRA);
`else
  assign w_shift = 1'b0;
  assign w_sra   = 1'b0;
`endif

  // A byte-wise shift loses the bit crossing the byte boundary; patch it from A.
  assign w_lo_byte = w_shift ? {r_a[8], bus.alu_out[6:0]} : bus.alu_out;
  assign w_hi_byte = w_sra ? {r_a[15], bus.alu_out[6:0]} : bus.alu_out;
  assign w_res16   = {w_hi_byte, r_res_lo};
  assign w_unused  = bus.alu_zout ^ bus.alu_nout;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.alu_a     = 8'd0;
    bus.alu_b     = 8'd0;
    bus.alu_mode  = 4'b0000;
    bus.alu_cin   = r_flag_c;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_state_nxt = S_LO;
      end
      S_LO: begin
        bus.alu_a    = r_a[7:0];
        bus.alu_b    = r_b[7:0];
        bus.alu_mode = alu_mode_for(r_op, 1'b0);
        bus.alu_cin  = r_seed;
        w_state_nxt  = S_HI;
      end
      S_HI: begin
        bus.alu_a    = r_a[15:8];
        bus.alu_b    = r_b[15:8];
        bus.alu_mode = alu_mode_for(r_op, 1'b1);
        bus.alu_cin  = r_chain_c;
        w_state_nxt  = S_DONE;
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flag_c     <= RST_FLAGS[2];
      r_flag_z     <= RST_FLAGS[1];
      r_flag_n     <= RST_FLAGS[0];
      r_rsp_result <= 16'd0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_op   <= bus.req_op;
            r_a    <= bus.req_a;
            r_b    <= bus.req_b;
            r_seed <= ((bus.req_op == OP_ADC) || (bus.req_op == OP_SBB)) & r_flag_c;
          end
        end
        S_LO: begin
          r_res_lo  <= w_lo_byte;
          r_chain_c <= bus.alu_cout;
        end
        S_HI: begin
          if (w_legal) begin
            r_rsp_err    <= 1'b0;
            r_rsp_result <= (r_op == OP_CMP) ? r_a : w_res16;
            r_flag_z     <= (w_res16 == 16'd0);
            r_flag_n     <= w_hi_byte[7];
            if (w_arith)      r_flag_c <= bus.alu_cout;
            else if (w_shift) r_flag_c <= r_a[0];
          end else begin
            r_rsp_err    <= 1'b1;
            r_rsp_result <= 16'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.flag_c     = r_flag_c;
  assign bus.flag_z     = r_flag_z;
  assign bus.flag_n     = r_flag_n;

endmodule

// File: tb/tb_alu16_seq.sv
// Directed bench for alu16_seq; the bench itself plays the 8-bit ALU.
// Build with ALU16_SHIFT_EN defined to exercise the shift ops.
module tb_alu16_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu16_seq_if bus();

  alu16_seq #(.RST_FLAGS(3'b000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [8:0] alu_t;
  always_comb begin
    alu_t = 9'd0;
    case (bus.alu_mode)
      4'b0001: alu_t = {1'b0, bus.alu_a & bus.alu_b};
      4'b0010: alu_t = {1'b0, bus.alu_a | bus.alu_b};
      4'b0011: alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
      4'b1001: alu_t = {1'b0, ~bus.alu_a};
      4'b0100: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      4'b0101: alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin};
      4'b0111: alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      4'b1000: alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'd0, bus.alu_cin};
      4'b1011: alu_t = {bus.alu_a[0], 1'b0, bus.alu_a[7:1]};
      4'b1100: alu_t = {bus.alu_a[0], bus.alu_a[7], bus.alu_a[7:1]};
      default: alu_t = 9'd0;
    endcase
    bus.alu_out  = alu_t[7:0];
    bus.alu_cout = alu_t[8];
    bus.alu_zout = (alu_t[7:0] == 8'd0);
    bus.alu_nout = alu_t[7];
  end

  // Issues one request and returns at #1 after the edge where rsp_valid first shows.
  // lat counts rising edges from the accept edge (inclusive) to that point.
  task automatic start_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic [3:0] m_lo, output logic [3:0] m_hi,
                          output logic c_lo, output logic c_hi);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL req_ready_timeout op=%0d req_ready=%b required=1", op, bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    m_lo = bus.alu_mode;
    c_lo = bus.alu_cin;
    @(posedge clk);
    #1;
    m_hi = bus.alu_mode;
    c_hi = bus.alu_cin;
    @(posedge clk);
    #1;
    lat = 3;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.rsp_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL rsp_valid_timeout op=%0d rsp_valid=%b required=1", op, bus.rsp_valid);
    end
  endtask

  task automatic finish_op();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake got ready=%b valid=%b required ready=1 valid=0",
               bus.req_ready, bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_result !== 16'h0000 || bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp got result=%h err=%b required 0000/0", bus.rsp_result, bus.rsp_err);
    end
    checks++;
    if ({bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000", {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_cin} !== 21'd0) begin
      failures++;
      $display("FAIL reset_alu got a=%h b=%h mode=%b cin=%b required all zero",
               bus.alu_a, bus.alu_b, bus.alu_mode, bus.alu_cin);
    end
    rst = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    logic [3:0] ml, mh;
    logic cl, ch;
    start_op(4'd0, 16'h12FF, 16'h0001, lat, ml, mh, cl, ch);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL add_latency got=%0d required=3", lat);
    end
    checks++;
    if (ml !== 4'b0100 || mh !== 4'b0101 || ch !== 1'b1) begin
      failures++;
      $display("FAIL add_modes got lo=%b hi=%b cin_hi=%b required 0100/0101/1", ml, mh, ch);
    end
    checks++;
    if (bus.rsp_result !== 16'h1300 || bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL add_result got=%h err=%b required=1300/0", bus.rsp_result, bus.rsp_err);
    end
    checks++;
    if ({bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b000) begin
      failures++;
      $display("FAIL add_flags got=%b required=000", {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    finish_op();
  endtask

  task automatic test_sub_sbb();
    int lat;
    logic [3:0] ml, mh;
    logic cl, ch;
    start_op(4'd2, 16'h0000, 16'h0001, lat, ml, mh, cl, ch);
    checks++;
    if (ml !== 4'b0111 || mh !== 4'b1000) begin
      failures++;
      $display("FAIL sub_modes got lo=%b hi=%b required 0111/1000", ml, mh);
    end
    checks++;
    if (bus.rsp_result !== 16'hFFFF || {bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b101) begin
      failures++;
      $display("FAIL sub_result got=%h flags=%b required=FFFF/101",
               bus.rsp_result, {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    finish_op();
    start_op(4'd3, 16'h0005, 16'h0002, lat, ml, mh, cl, ch);
    checks++;
    if (cl !== 1'b1) begin
      failures++;
      $display("FAIL sbb_seed got cin_lo=%b required=1", cl);
    end
    checks++;
    if (bus.rsp_result !== 16'h0002 || {bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b000) begin
      failures++;
      $display("FAIL sbb_result got=%h flags=%b required=0002/000",
               bus.rsp_result, {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    finish_op();
  endtask

  task automatic test_cmp();
    int lat;
    logic [3:0] ml, mh;
    logic cl, ch;
    start_op(4'd8, 16'h1234, 16'h1234, lat, ml, mh, cl, ch);
    checks++;
    if (bus.rsp_result !== 16'h1234 || {bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b010) begin
      failures++;
      $display("FAIL cmp_equal got=%h flags=%b required=1234/010",
               bus.rsp_result, {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    finish_op();
    start_op(4'd8, 16'h0100, 16'h0200, lat, ml, mh, cl, ch);
    checks++;
    if (bus.rsp_result !== 16'h0100 || {bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b101) begin
      failures++;
      $display("FAIL cmp_less got=%h flags=%b required=0100/101",
               bus.rsp_result, {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    finish_op();
  endtask

  task automatic test_and_hold();
    int lat;
    logic [3:0] ml, mh;
    logic cl, ch;
    start_op(4'd4, 16'hF0F0, 16'h0FF0, lat, ml, mh, cl, ch);
    checks++;
    if (bus.rsp_result !== 16'h00F0 || {bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b100) begin
      failures++;
      $display("FAIL and_result got=%h flags=%b required=00F0/100",
               bus.rsp_result, {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h00F0 || bus.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL and_hold cycle=%0d got valid=%b result=%h ready=%b required 1/00F0/0",
                 i, bus.rsp_valid, bus.rsp_result, bus.req_ready);
      end
    end
    finish_op();
  endtask

  task automatic test_illegal();
    int lat;
    logic [3:0] ml, mh;
    logic cl, ch;
    start_op(4'hF, 16'h1234, 16'h5678, lat, ml, mh, cl, ch);
    checks++;
    if (ml !== 4'b0000 || mh !== 4'b0000) begin
      failures++;
      $display("FAIL illegal_modes got lo=%b hi=%b required 0000/0000", ml, mh);
    end
    checks++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_result !== 16'h0000 ||
        {bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b100) begin
      failures++;
      $display("FAIL illegal_rsp got err=%b result=%h flags=%b required 1/0000/100",
               bus.rsp_err, bus.rsp_result, {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    finish_op();
  endtask

  task automatic test_shift();
    int lat;
    logic [3:0] ml, mh;
    logic cl, ch;
    logic [15:0] exp_res;
    logic        exp_err;
    logic [2:0]  exp_flags;
`ifdef ALU16_SHIFT_EN
    exp_res = 16'hC080; exp_err = 1'b0; exp_flags = 3'b101;
`else
    exp_res = 16'h0000; exp_err = 1'b1; exp_flags = 3'b100;
`endif
    start_op(4'd10, 16'h8101, 16'h0000, lat, ml, mh, cl, ch);
    checks++;
    if (bus.rsp_result !== exp_res || bus.rsp_err !== exp_err ||
        {bus.flag_c, bus.flag_z, bus.flag_n} !== exp_flags) begin
      failures++;
      $display("FAIL sra16 got result=%h err=%b flags=%b required %h/%b/%b",
               bus.rsp_result, bus.rsp_err, {bus.flag_c, bus.flag_z, bus.flag_n},
               exp_res, exp_err, exp_flags);
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd0;
    bus.req_a     = 16'hFFFF;
    bus.req_b     = 16'h0001;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.alu_mode !== 4'b0101 || bus.alu_cin !== 1'b1) begin
      failures++;
      $display("FAIL midrst_in_hi got mode=%b cin=%b required 0101/1", bus.alu_mode, bus.alu_cin);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        {bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_state got valid=%b ready=%b flags=%b required 0/1/000",
               bus.rsp_valid, bus.req_ready, {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midrst_no_rsp got valid_cycles=%0d required=0", seen);
    end
  endtask

  task automatic test_logic();
    int lat;
    logic [3:0] ml, mh;
    logic cl, ch;
    start_op(4'd5, 16'h1200, 16'h0034, lat, ml, mh, cl, ch);
    checks++;
    if (bus.rsp_result !== 16'h1234 || {bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b000) begin
      failures++;
      $display("FAIL or16 got=%h flags=%b required=1234/000",
               bus.rsp_result, {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    finish_op();
    start_op(4'd6, 16'hFFFF, 16'hFFFF, lat, ml, mh, cl, ch);
    checks++;
    if (bus.rsp_result !== 16'h0000 || {bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b010) begin
      failures++;
      $display("FAIL xor16 got=%h flags=%b required=0000/010",
               bus.rsp_result, {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    finish_op();
    start_op(4'd7, 16'h00FF, 16'h0000, lat, ml, mh, cl, ch);
    checks++;
    if (bus.rsp_result !== 16'hFF00 || {bus.flag_c, bus.flag_z, bus.flag_n} !== 3'b001) begin
      failures++;
      $display("FAIL not16 got=%h flags=%b required=FF00/001",
               bus.rsp_result, {bus.flag_c, bus.flag_z, bus.flag_n});
    end
    finish_op();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = 16'd0;
    bus.req_b     = 16'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_sbb();
    test_cmp();
    test_and_hold();
    test_illegal();
    test_shift();
    test_reset_mid();
    test_logic();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
